// File: rtl/xadc_pkg.sv
// Shared DRP definitions for the XADC write path: bus widths, FSM state encoding
// and the XADC register addresses that the board sequencers program.
package xadc_pkg;

   localparam int DRP_ADDR_W = 7;
   localparam int DRP_DATA_W = 16;

   localparam logic [6:0] XADC_CFG0         = 7'h40;
   localparam logic [6:0] XADC_CFG1         = 7'h41;
   localparam logic [6:0] XADC_CFG2         = 7'h42;
   localparam logic [6:0] XADC_VAUX11_STAT  = 7'h1B;

   // The read-back states are only reachable when XADC_DRP_VERIFY_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_ISSUE = 3'd1,
      ST_WR_WAIT  = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_WAIT  = 3'd4
   } drp_state_t;

endpackage

// File: rtl/drp_timeout_ctr.sv
// Wait-cycle counter for DRP accesses: cleared outside the wait states, counts while
// enabled and flags expiry on the TIMEOUT_CYC-th enabled cycle.
module drp_timeout_ctr #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_count;

   // Saturates at LAST so a late drdy on the final wait cycle still wins over expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en && (r_count != LAST)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/xadc_drp_writer.sv
// DRP write initiator for xadc_wiz_0: one valid/ready request, single den pulse, waits drdy.
// Optional read-back check enabled by defining XADC_DRP_VERIFY_EN.
module xadc_drp_writer
   import xadc_pkg::*;
#(
   parameter int ADDR_W      = DRP_ADDR_W,
   parameter int DATA_W      = DRP_DATA_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              CLK100MHZ,
   input  logic              CPU_RESETN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              done,
   output logic              err_timeout,
   output logic              err_verify,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] daddr,
   output logic              den,
   output logic              dwe,
   output logic [DATA_W-1:0] di,
   input  logic [DATA_W-1:0] drp_do,
   input  logic              drdy,
   input  logic              drp_busy
);

   drp_state_t        r_state;
   logic              r_ready;
   logic              r_done;
   logic              r_den;
   logic              r_dwe;
   logic [ADDR_W-1:0] r_daddr;
   logic [DATA_W-1:0] r_di;
   logic              r_err_timeout;
   logic              w_in_wait;
   logic              w_expire;

`ifdef XADC_DRP_VERIFY_EN
   logic              r_err_verify;
   assign w_in_wait = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
`else
   assign w_in_wait = (r_state == ST_WR_WAIT);
`endif

   drp_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (CLK100MHZ),
      .rst_n    (CPU_RESETN),
      .i_clear  (!w_in_wait),
      .i_en     (w_in_wait),
      .o_expire (w_expire)
   );

   // daddr/di double as the latched request, so they stay stable until the next accept.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state       <= ST_IDLE;
         r_ready       <= 1'b0;
         r_done        <= 1'b0;
         r_den         <= 1'b0;
         r_dwe         <= 1'b0;
         r_daddr       <= '0;
         r_di          <= '0;
         r_err_timeout <= 1'b0;
`ifdef XADC_DRP_VERIFY_EN
         r_err_verify  <= 1'b0;
`endif
      end else begin
         r_den  <= 1'b0;
         r_dwe  <= 1'b0;
         r_done <= 1'b0;
         if (err_clr) begin
            r_err_timeout <= 1'b0;
`ifdef XADC_DRP_VERIFY_EN
            r_err_verify  <= 1'b0;
`endif
         end
         case (r_state)
            ST_IDLE: begin
               if (req_valid && r_ready) begin
                  r_daddr <= req_addr;
                  r_di    <= req_data;
                  r_den   <= 1'b1;
                  r_dwe   <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= ST_WR_ISSUE;
               end else begin
                  r_ready <= !drp_busy;
               end
            end
            ST_WR_ISSUE: begin
               r_state <= ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
               if (drdy) begin
`ifdef XADC_DRP_VERIFY_EN
                  r_den   <= 1'b1;
                  r_state <= ST_RD_ISSUE;
`else
                  r_done  <= 1'b1;
                  r_ready <= !drp_busy;
                  r_state <= ST_IDLE;
`endif
               end else if (w_expire) begin
                  r_err_timeout <= 1'b1;
                  r_done        <= 1'b1;
                  r_ready       <= !drp_busy;
                  r_state       <= ST_IDLE;
               end
            end
`ifdef XADC_DRP_VERIFY_EN
            ST_RD_ISSUE: begin
               r_state <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (drdy) begin
                  if (drp_do != r_di) begin
                     r_err_verify <= 1'b1;
                  end
                  r_done  <= 1'b1;
                  r_ready <= !drp_busy;
                  r_state <= ST_IDLE;
               end else if (w_expire) begin
                  r_err_timeout <= 1'b1;
                  r_done        <= 1'b1;
                  r_ready       <= !drp_busy;
                  r_state       <= ST_IDLE;
               end
            end
`endif
            default: begin
               r_ready <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = r_ready;
   assign done        = r_done;
   assign den         = r_den;
   assign dwe         = r_dwe;
   assign daddr       = r_daddr;
   assign di          = r_di;
   assign err_timeout = r_err_timeout;

`ifdef XADC_DRP_VERIFY_EN
   assign err_verify = r_err_verify;
`else
   logic w_unused_do;
   assign w_unused_do = ^drp_do;
   assign err_verify  = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_writer.sv
// Directed bench for xadc_drp_writer with a DRP responder model that answers den
// after a programmable delay; works with or without XADC_DRP_VERIFY_EN.
module tb_xadc_drp_writer;
   import xadc_pkg::*;

   localparam int TIMEOUT_CYC = 255;
`ifdef XADC_DRP_VERIFY_EN
   localparam int RD_PER_REQ     = 1;
   localparam int VERIFY_ERR_EXP = 1;
`else
   localparam int RD_PER_REQ     = 0;
   localparam int VERIFY_ERR_EXP = 0;
`endif

   logic        clock = 1'b0;
   logic        rstN;
   logic        reqValid;
   logic        reqReady;
   logic [6:0]  reqAddr;
   logic [15:0] reqData;
   logic        done;
   logic        errTimeout;
   logic        errVerify;
   logic        errClr;
   logic [6:0]  daddr;
   logic        den;
   logic        dwe;
   logic [15:0] di;
   logic [15:0] drpDo;
   logic        drdy;
   logic        drpBusy;

   always #5 clock = ~clock;

   xadc_drp_writer #(
      .ADDR_W      (DRP_ADDR_W),
      .DATA_W      (DRP_DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .CLK100MHZ   (clock),
      .CPU_RESETN  (rstN),
      .req_valid   (reqValid),
      .req_ready   (reqReady),
      .req_addr    (reqAddr),
      .req_data    (reqData),
      .done        (done),
      .err_timeout (errTimeout),
      .err_verify  (errVerify),
      .err_clr     (errClr),
      .daddr       (daddr),
      .den         (den),
      .dwe         (dwe),
      .di          (di),
      .drp_do      (drpDo),
      .drdy        (drdy),
      .drp_busy    (drpBusy)
   );

   int          assertCount = 0;
   int          failCount   = 0;
   int          cycNum      = 0;
   int          respDelay   = 3;
   int          countdown   = 0;
   logic [15:0] respMem     = 16'h0000;
   logic [15:0] corruptMask = 16'h0000;
   logic        strayReq    = 1'b0;
   int          wrDenCount  = 0;
   int          rdDenCount  = 0;
   int          doneCount   = 0;
   int          lastDenCyc  = 0;
   int          lastWrCyc   = 0;
   int          lastDoneCyc = 0;
   logic [6:0]  lastWrAddr  = 7'h00;
   logic [6:0]  lastRdAddr  = 7'h00;
   logic [15:0] lastWrDi    = 16'h0000;

   // Responder and monitor share one negedge process so their bookkeeping never races.
   initial begin : responder
      drdy  = 1'b0;
      drpDo = 16'h0000;
      forever begin
         @(negedge clock);
         cycNum++;
         drdy = 1'b0;
         if (!rstN) begin
            countdown = 0;
         end else if (strayReq) begin
            drdy     = 1'b1;
            strayReq = 1'b0;
         end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               drdy  = 1'b1;
               drpDo = respMem ^ corruptMask;
            end
         end
         if (den) begin
            lastDenCyc = cycNum;
            if (dwe) begin
               wrDenCount++;
               lastWrCyc  = cycNum;
               lastWrAddr = daddr;
               lastWrDi   = di;
               respMem    = di;
            end else begin
               rdDenCount++;
               lastRdAddr = daddr;
            end
            countdown = respDelay;
         end
         if (done) begin
            doneCount++;
            lastDoneCyc = cycNum;
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] addr, input logic [15:0] data, output int acceptCyc);
      int n;
      n         = 0;
      acceptCyc = -1;
      reqValid  = 1'b1;
      reqAddr   = addr;
      reqData   = data;
      while (!reqReady && n < 50) begin
         waitCycles(1);
         n++;
      end
      if (reqReady) acceptCyc = cycNum;
      else checkOutput("acceptSeen", 32'd0, 32'd1);
      waitCycles(1);
      reqValid = 1'b0;
   endtask

   task automatic waitDone(input int bound, input int startCount);
      int n;
      n = 0;
      while (doneCount == startCount && n < bound) begin
         waitCycles(1);
         n++;
      end
      checkOutput("doneSeen", 32'(doneCount != startCount), 32'd1);
   endtask

   initial begin : stimulus
      int acc, w0, r0, d0, dropCyc;
      rstN     = 1'b0;
      reqValid = 1'b0;
      reqAddr  = 7'h00;
      reqData  = 16'h0000;
      errClr   = 1'b0;
      drpBusy  = 1'b0;
      waitCycles(2);
      checkOutput("rstReady", 32'(reqReady), 32'd0);
      checkOutput("rstDen", 32'(den), 32'd0);
      checkOutput("rstDwe", 32'(dwe), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstErrT", 32'(errTimeout), 32'd0);
      checkOutput("rstErrV", 32'(errVerify), 32'd0);
      checkOutput("rstDaddr", 32'(daddr), 32'h0);
      checkOutput("rstDi", 32'(di), 32'h0);
      rstN = 1'b1;
      waitCycles(1);
      checkOutput("readyAfterRst", 32'(reqReady), 32'd1);

      // Basic write, drdy three cycles after den.
      respDelay = 3;
      w0 = wrDenCount; r0 = rdDenCount; d0 = doneCount;
      applyStimulus(XADC_CFG1, 16'h2100, acc);
      waitDone(50, d0);
      waitCycles(3);
      checkOutput("t1WrDens", 32'(wrDenCount - w0), 32'd1);
      checkOutput("t1RdDens", 32'(rdDenCount - r0), 32'(RD_PER_REQ));
      checkOutput("t1Addr", 32'(lastWrAddr), 32'h41);
      checkOutput("t1Di", 32'(lastWrDi), 32'h2100);
      checkOutput("t1AcceptToDen", 32'(lastWrCyc - acc), 32'd1);
      checkOutput("t1DrdyToDone", 32'(lastDoneCyc - lastDenCyc), 32'd4);
      checkOutput("t1DoneOnce", 32'(doneCount - d0), 32'd1);
      checkOutput("t1ErrT", 32'(errTimeout), 32'd0);
      checkOutput("t1ErrV", 32'(errVerify), 32'd0);

      // Busy holds off acceptance; accept one cycle after drop, den the cycle after.
      respDelay = 2;
      drpBusy = 1'b1;
      waitCycles(1);
      checkOutput("t2BusyReady", 32'(reqReady), 32'd0);
      w0 = wrDenCount; d0 = doneCount;
      reqValid = 1'b1; reqAddr = XADC_CFG0; reqData = 16'h1234;
      waitCycles(4);
      checkOutput("t2BusyReadyHeld", 32'(reqReady), 32'd0);
      checkOutput("t2NoDen", 32'(wrDenCount - w0), 32'd0);
      drpBusy = 1'b0;
      dropCyc = cycNum;
      waitCycles(1);
      checkOutput("t2ReadyAfterDrop", 32'(reqReady), 32'd1);
      waitCycles(1);
      reqValid = 1'b0;
      checkOutput("t2DenCyc", 32'(lastWrCyc - dropCyc), 32'd2);
      checkOutput("t2Addr", 32'(lastWrAddr), 32'h40);
      waitDone(50, d0);

      // Responder silent: timeout after TIMEOUT_CYC wait cycles.
      waitCycles(3);
      respDelay = 0;
      d0 = doneCount;
      applyStimulus(XADC_CFG2, 16'h0F0F, acc);
      waitDone(400, d0);
      waitCycles(2);
      checkOutput("t3ErrT", 32'(errTimeout), 32'd1);
      checkOutput("t3DoneCyc", 32'(lastDoneCyc - lastWrCyc), 32'(TIMEOUT_CYC + 1));
      checkOutput("t3DoneOnce", 32'(doneCount - d0), 32'd1);
      checkOutput("t3ErrV", 32'(errVerify), 32'd0);
      waitCycles(5);
      checkOutput("t3ErrSticky", 32'(errTimeout), 32'd1);
      errClr = 1'b1;
      waitCycles(1);
      errClr = 1'b0;
      checkOutput("t3ErrCleared", 32'(errTimeout), 32'd0);

      // Stray drdy while idle must be ignored.
      w0 = wrDenCount; d0 = doneCount;
      strayReq = 1'b1;
      waitCycles(4);
      checkOutput("t6StrayDone", 32'(doneCount - d0), 32'd0);
      checkOutput("t6StrayDen", 32'(wrDenCount - w0), 32'd0);
      checkOutput("t6StrayReady", 32'(reqReady), 32'd1);
      checkOutput("t6StrayErrT", 32'(errTimeout), 32'd0);

      // drdy on the last wait cycle wins over expiry.
      respDelay = TIMEOUT_CYC;
      d0 = doneCount;
      applyStimulus(XADC_VAUX11_STAT, 16'h00AA, acc);
      waitDone(700, d0);
      waitCycles(2);
      checkOutput("t6EdgeErrT", 32'(errTimeout), 32'd0);
      checkOutput("t6EdgeDoneCyc", 32'(lastDoneCyc - lastDenCyc), 32'(TIMEOUT_CYC + 1));
      checkOutput("t6EdgeDoneOnce", 32'(doneCount - d0), 32'd1);

      // Read-back returns corrupted data: error only when verify is built in.
      respDelay = 2;
      corruptMask = 16'h0100;
      r0 = rdDenCount; d0 = doneCount;
      applyStimulus(XADC_CFG2, 16'h3F00, acc);
      waitDone(50, d0);
      waitCycles(2);
      checkOutput("t4ErrV", 32'(errVerify), 32'(VERIFY_ERR_EXP));
      checkOutput("t4RdDens", 32'(rdDenCount - r0), 32'(RD_PER_REQ));
      checkOutput("t4DoneOnce", 32'(doneCount - d0), 32'd1);
      checkOutput("t4Di", 32'(lastWrDi), 32'h3F00);
`ifdef XADC_DRP_VERIFY_EN
      checkOutput("t4RdAddr", 32'(lastRdAddr), 32'h42);
`endif
      errClr = 1'b1;
      waitCycles(1);
      errClr = 1'b0;
      corruptMask = 16'h0000;
      d0 = doneCount;
      applyStimulus(XADC_CFG2, 16'h3F00, acc);
      waitDone(50, d0);
      waitCycles(2);
      checkOutput("t4MatchErrV", 32'(errVerify), 32'd0);
      checkOutput("t4MatchDone", 32'(doneCount - d0), 32'd1);

      // Reset during the den cycle drops den/dwe at once and leaves no stale done.
      respDelay = 0;
      d0 = doneCount;
      applyStimulus(XADC_CFG0, 16'h5555, acc);
      checkOutput("t5DenBefore", 32'(den), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("t5DenAsync", 32'(den), 32'd0);
      checkOutput("t5DweAsync", 32'(dwe), 32'd0);
      checkOutput("t5DoneAsync", 32'(done), 32'd0);
      waitCycles(2);
      rstN = 1'b1;
      waitCycles(1);
      checkOutput("t5ReadyAfter", 32'(reqReady), 32'd1);
      waitCycles(300);
      checkOutput("t5NoStaleDone", 32'(doneCount - d0), 32'd0);
      checkOutput("t5NoErrT", 32'(errTimeout), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
